// File: rtl/keypad_scan_4x4_if.sv
// Keypad scanner signal bundle: matrix pins plus debounced key outputs.
// master = scanner side, slave = board/consumer side.
interface keypad_scan_4x4_if;
   logic [3:0]  KEY_ROW;    // row returns, active-low
   logic [3:0]  KEY_COL;    // column drives, active-low one-hot
   logic [15:0] key_state;  // debounced pressed bitmap, index = col*4 + row
   logic        key_valid;  // one-cycle pulse on a newly committed press
   logic [3:0]  key_code;   // lowest newly pressed key of the last press commit

   modport master (
      input  KEY_ROW,
      output KEY_COL,
      output key_state,
      output key_valid,
      output key_code
   );

   modport slave (
      output KEY_ROW,
      input  KEY_COL,
      input  key_state,
      input  key_valid,
      input  key_code
   );
endinterface

// File: rtl/keypad_scan_4x4.sv
// 4x4 key matrix scanner: drives one active-low column per slot, samples
// synchronised row returns at the end of each slot, debounces whole frames
// and reports newly pressed keys as a one-cycle event with a key code.
// SCAN_DIV must be >= 4 and DEBOUNCE >= 2.
module keypad_scan_4x4 #(
   parameter int unsigned SCAN_DIV = 50000,
   parameter int unsigned DEBOUNCE = 4
) (
   input logic                 CLK,
   input logic                 RSTN,
   keypad_scan_4x4_if.master   kp
);

   localparam int unsigned DIV_W = $clog2(SCAN_DIV);
   localparam int unsigned CNT_W = $clog2(DEBOUNCE + 1);

   localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(SCAN_DIV - 1);
   localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(DEBOUNCE);
   localparam logic [CNT_W-1:0] CNT_COMMIT = CNT_W'(DEBOUNCE - 1);

   // Row synchroniser
   logic [3:0]       r_row_meta;
   logic [3:0]       r_row_sync;

   // Scan timing
   logic [DIV_W-1:0] r_div;
   logic [1:0]       r_col;
   logic [3:0]       r_key_col;

   // Frame capture and debounce
   logic [15:0]      r_raw;
   logic [15:0]      r_prev;
   logic [CNT_W-1:0] r_cnt;

   // Committed outputs
   logic [15:0]      r_key_state;
   logic             r_key_valid;
   logic [3:0]       r_key_code;

   // Combinational helpers
   logic             w_slot_end;
   logic             w_frame_end;
   logic [1:0]       w_col_next;
   logic [15:0]      w_frame;
   logic             w_match;
   logic             w_commit;
   logic [15:0]      w_new;
   logic [3:0]       w_low_idx;

   assign w_slot_end  = (r_div == DIV_LAST);
   assign w_frame_end = w_slot_end && (r_col == 2'd3);
   assign w_col_next  = r_col + 2'd1;
   assign w_match     = (w_frame == r_prev);
   assign w_commit    = w_frame_end && w_match && (r_cnt == CNT_COMMIT);
   assign w_new       = w_frame & ~r_key_state;

   // Two-flop synchroniser for the asynchronous row returns (idle high)
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         r_row_meta <= 4'b1111;
         r_row_sync <= 4'b1111;
      end else begin
         r_row_meta <= kp.KEY_ROW;
         r_row_sync <= r_row_meta;
      end
   end

   // Slot divider: SCAN_DIV cycles per column
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         r_div <= '0;
      end else if (w_slot_end) begin
         r_div <= '0;
      end else begin
         r_div <= r_div + 1'b1;
      end
   end

   // Column counter and registered one-hot active-low column drive
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         r_col     <= '0;
         r_key_col <= 4'b1110;
      end else if (w_slot_end) begin
         r_col     <= w_col_next;
         r_key_col <= ~(4'b0001 << w_col_next);
      end
   end

   // Frame vector as it stands after this cycle's sample: the stored raw
   // bits with the current column's four bits replaced by the live rows.
   always_comb begin
      w_frame = r_raw;
      for (int unsigned r = 0; r < 4; r++) begin
         w_frame[{r_col, 2'(r)}] = ~r_row_sync[r];
      end
   end

   // Sample the active column on the last cycle of its slot
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         r_raw <= '0;
      end else if (w_slot_end) begin
         r_raw <= w_frame;
      end
   end

   // Frame-level debounce: count consecutive identical frames, saturating
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         r_prev <= '0;
         r_cnt  <= '0;
      end else if (w_frame_end) begin
         r_prev <= w_frame;
         if (!w_match) begin
            r_cnt <= CNT_W'(1);
         end else if (r_cnt < CNT_MAX) begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

   // Lowest set bit of the newly pressed keys
   always_comb begin
      w_low_idx = '0;
      for (int unsigned i = 16; i > 0; i--) begin
         if (w_new[i-1]) begin
            w_low_idx = 4'(i - 1);
         end
      end
   end

   // Commit debounced state; only new presses raise the event and move the code
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         r_key_state <= '0;
         r_key_valid <= 1'b0;
         r_key_code  <= '0;
      end else begin
         r_key_valid <= 1'b0;
         if (w_commit) begin
            r_key_state <= w_frame;
            if (|w_new) begin
               r_key_valid <= 1'b1;
               r_key_code  <= w_low_idx;
            end
         end
      end
   end

   assign kp.KEY_COL   = r_key_col;
   assign kp.key_state = r_key_state;
   assign kp.key_valid = r_key_valid;
   assign kp.key_code  = r_key_code;

endmodule

// File: tb/tb_keypad_scan_4x4.sv
// Directed bench for keypad_scan_4x4 with SCAN_DIV = 8, DEBOUNCE = 3.
// Cycle n = state observed at the falling edge after n rising edges since
// reset release. Frame k ends on the edge closing cycle 32k+31, so a commit
// at the end of frame k is visible in cycle 32(k+1).
module tb_keypad_scan_4x4;

   logic        clk = 1'b0;
   logic        rstn;
   logic [15:0] keys;
   logic [3:0]  tb_row;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;
   int pulses = 0;
   logic [3:0] pulse_code;

   keypad_scan_4x4_if kp_if ();

   keypad_scan_4x4 #(
      .SCAN_DIV (8),
      .DEBOUNCE (3)
   ) dut (
      .CLK  (clk),
      .RSTN (rstn),
      .kp   (kp_if)
   );

   always #5 clk = ~clk;

   // Matrix model: held key (c,r) pulls row r low while column c is driven
   always_comb begin
      tb_row = 4'b1111;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            if (keys[c*4+r] && !kp_if.KEY_COL[c]) tb_row[r] = 1'b0;
         end
      end
      kp_if.KEY_ROW = tb_row;
   end

   task automatic step();
      @(posedge clk);
      @(negedge clk);
      cyc++;
      if (kp_if.key_valid === 1'b1) begin
         pulses++;
         pulse_code = kp_if.key_code;
      end
   endtask

   task automatic run_to(input int target);
      while (cyc < target) step();
   endtask

   task automatic start(input logic [15:0] k);
      rstn = 1'b0;
      keys = k;
      repeat (2) @(negedge clk);
      rstn   = 1'b1;
      cyc    = 0;
      pulses = 0;
   endtask

   task automatic test_reset();
      logic [3:0] exp_col;
      rstn = 1'b0;
      keys = '0;
      repeat (3) @(negedge clk);
      tests++;
      if (kp_if.KEY_COL !== 4'b1110) begin
         fails++; $display("FAIL rst_col got %b want 1110", kp_if.KEY_COL);
      end
      tests++;
      if (kp_if.key_state !== 16'h0000 || kp_if.key_valid !== 1'b0 || kp_if.key_code !== 4'd0) begin
         fails++; $display("FAIL rst_outs got state=%h valid=%b code=%0d want 0/0/0",
                           kp_if.key_state, kp_if.key_valid, kp_if.key_code);
      end
      rstn = 1'b1; cyc = 0; pulses = 0;
      for (int n = 0; n < 40; n++) begin
         exp_col = ~(4'b0001 << ((n / 8) % 4));
         tests++;
         if (kp_if.KEY_COL !== exp_col) begin
            fails++; $display("FAIL scan_col cyc=%0d got %b want %b", cyc, kp_if.KEY_COL, exp_col);
         end
         tests++;
         if (kp_if.key_state !== 16'h0000 || kp_if.key_valid !== 1'b0 || kp_if.key_code !== 4'd0) begin
            fails++; $display("FAIL scan_idle cyc=%0d got state=%h valid=%b code=%0d want 0/0/0",
                              cyc, kp_if.key_state, kp_if.key_valid, kp_if.key_code);
         end
         step();
      end
   endtask

   task automatic test_single_press();
      start(16'h0040);
      run_to(95);
      tests++;
      if (pulses !== 0 || kp_if.key_state !== 16'h0000) begin
         fails++; $display("FAIL single_early got pulses=%0d state=%h want 0/0000", pulses, kp_if.key_state);
      end
      step();
      tests++;
      if (kp_if.key_valid !== 1'b1 || kp_if.key_code !== 4'd6 || kp_if.key_state !== 16'h0040) begin
         fails++; $display("FAIL single_commit got valid=%b code=%0d state=%h want 1/6/0040",
                           kp_if.key_valid, kp_if.key_code, kp_if.key_state);
      end
      step();
      tests++;
      if (kp_if.key_valid !== 1'b0) begin
         fails++; $display("FAIL single_width got valid=%b want 0", kp_if.key_valid);
      end
      run_to(200);
      tests++;
      if (pulses !== 1 || kp_if.key_state !== 16'h0040 || kp_if.key_code !== 4'd6) begin
         fails++; $display("FAIL single_hold got pulses=%0d state=%h code=%0d want 1/0040/6",
                           pulses, kp_if.key_state, kp_if.key_code);
      end
   endtask

   task automatic test_bounce();
      start(16'h0000);
      for (int f = 0; f < 5; f++) begin
         keys = (f % 2 == 1) ? 16'h0040 : 16'h0000;
         run_to(32 * (f + 1));
         tests++;
         if (pulses !== 0 || kp_if.key_state !== 16'h0000) begin
            fails++; $display("FAIL bounce_frame%0d got pulses=%0d state=%h want 0/0000",
                              f, pulses, kp_if.key_state);
         end
      end
      keys = 16'h0040;
      run_to(255);
      tests++;
      if (pulses !== 0 || kp_if.key_state !== 16'h0000) begin
         fails++; $display("FAIL bounce_hold_early got pulses=%0d state=%h want 0/0000", pulses, kp_if.key_state);
      end
      step();
      tests++;
      if (kp_if.key_valid !== 1'b1 || kp_if.key_code !== 4'd6 || kp_if.key_state !== 16'h0040) begin
         fails++; $display("FAIL bounce_commit got valid=%b code=%0d state=%h want 1/6/0040",
                           kp_if.key_valid, kp_if.key_code, kp_if.key_state);
      end
   endtask

   task automatic test_simultaneous();
      start(16'h0208);
      run_to(96);
      tests++;
      if (kp_if.key_valid !== 1'b1 || kp_if.key_code !== 4'd3 || kp_if.key_state !== 16'h0208) begin
         fails++; $display("FAIL simul_commit got valid=%b code=%0d state=%h want 1/3/0208",
                           kp_if.key_valid, kp_if.key_code, kp_if.key_state);
      end
      run_to(160);
      tests++;
      if (pulses !== 1 || pulse_code !== 4'd3) begin
         fails++; $display("FAIL simul_pulses got pulses=%0d code=%0d want 1/3", pulses, pulse_code);
      end
   endtask

   task automatic test_release_repress();
      start(16'h0040);
      run_to(128);
      keys = 16'h0000;
      run_to(223);
      tests++;
      if (pulses !== 1 || kp_if.key_state !== 16'h0040) begin
         fails++; $display("FAIL release_early got pulses=%0d state=%h want 1/0040", pulses, kp_if.key_state);
      end
      step();
      tests++;
      if (kp_if.key_state !== 16'h0000 || kp_if.key_valid !== 1'b0 || kp_if.key_code !== 4'd6) begin
         fails++; $display("FAIL release_commit got state=%h valid=%b code=%0d want 0000/0/6",
                           kp_if.key_state, kp_if.key_valid, kp_if.key_code);
      end
      keys = 16'h0040;
      run_to(319);
      tests++;
      if (pulses !== 1 || kp_if.key_state !== 16'h0000) begin
         fails++; $display("FAIL repress_early got pulses=%0d state=%h want 1/0000", pulses, kp_if.key_state);
      end
      step();
      tests++;
      if (kp_if.key_valid !== 1'b1 || kp_if.key_code !== 4'd6 || kp_if.key_state !== 16'h0040) begin
         fails++; $display("FAIL repress_commit got valid=%b code=%0d state=%h want 1/6/0040",
                           kp_if.key_valid, kp_if.key_code, kp_if.key_state);
      end
   endtask

   task automatic test_reset_mid_debounce();
      start(16'h0040);
      run_to(84);
      tests++;
      if (kp_if.KEY_COL !== 4'b1011) begin
         fails++; $display("FAIL midrst_pre_col got %b want 1011", kp_if.KEY_COL);
      end
      rstn = 1'b0;
      #1;
      tests++;
      if (kp_if.KEY_COL !== 4'b1110 || kp_if.key_state !== 16'h0000 ||
          kp_if.key_valid !== 1'b0 || kp_if.key_code !== 4'd0) begin
         fails++; $display("FAIL midrst_async got col=%b state=%h valid=%b code=%0d want 1110/0000/0/0",
                           kp_if.KEY_COL, kp_if.key_state, kp_if.key_valid, kp_if.key_code);
      end
      repeat (2) @(negedge clk);
      rstn = 1'b1; cyc = 0; pulses = 0;
      run_to(95);
      tests++;
      if (pulses !== 0 || kp_if.key_state !== 16'h0000) begin
         fails++; $display("FAIL midrst_early got pulses=%0d state=%h want 0/0000", pulses, kp_if.key_state);
      end
      step();
      tests++;
      if (kp_if.key_valid !== 1'b1 || kp_if.key_code !== 4'd6 || kp_if.key_state !== 16'h0040) begin
         fails++; $display("FAIL midrst_commit got valid=%b code=%0d state=%h want 1/6/0040",
                           kp_if.key_valid, kp_if.key_code, kp_if.key_state);
      end
   endtask

   initial begin
      rstn = 1'b0;
      keys = '0;
      test_reset();
      test_single_press();
      test_bounce();
      test_simultaneous();
      test_release_repress();
      test_reset_mid_debounce();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog timeout at cyc=%0d", cyc);
      $fatal(1, "timeout");
   end

endmodule
